csm_arbiter: RTL and testbench



---
 rtl/csm_pkg.sv | 52 +++++
 rtl/csm_port_capture.sv | 73 +++++++
 rtl/csm_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_csm_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// Shared types, error codes and op decoding for the CSM bus arbiter.
package csm_pkg;

    typedef enum logic [2:0] {
        OP_READ    = 3'd0,
        OP_WRITE   = 3'd1,
        OP_HOLD    = 3'd2,
        OP_RELEASE = 3'd3,
        OP_BAD     = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RD   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_WDATA = 2'd1,
        P_PEND  = 2'd2
    } port_state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_LOCKED    = 2'b01;
    localparam logic [1:0] ERR_NOT_OWNER = 2'b10;
    localparam logic [1:0] ERR_PROTO     = 2'b11;

    // Lock controls take precedence over rw; asserting both is a protocol error.
    function automatic op_t decode_op(input logic rw, input logic hold, input logic rel);
        op_t op;
        if (hold && rel) begin
            op = OP_BAD;
        end else if (hold) begin
            op = OP_HOLD;
        end else if (rel) begin
            op = OP_RELEASE;
        end else if (rw) begin
            op = OP_WRITE;
        end else begin
            op = OP_READ;
        end
        return op;
    endfunction

endpackage

// File: rtl/csm_port_capture.sv
// Per-processor request capture: latches op/address in the enable cycle and
// write data in the following cycle, then holds the request until serviced.
module csm_port_capture
    import csm_pkg::*;
#(
    parameter int DATABITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATABITS-1:0] in_ad,
    input  logic                rw,
    input  logic                enable,
    input  logic                hold,
    input  logic                rel,
    input  logic                done,
    output logic                ack,
    output logic                pend,
    output op_t                 op,
    output logic [DATABITS-1:0] addr,
    output logic [DATABITS-1:0] wdata
);

    port_state_t state_r;
    port_state_t state_nxt_s;
    op_t         dec_op_s;

    assign dec_op_s = decode_op(rw, hold, rel);
    assign ack      = (state_r == P_IDLE);
    assign pend     = (state_r == P_PEND);

    // Next-state logic; enable is only honoured while idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            P_IDLE: begin
                if (enable) begin
                    state_nxt_s = (dec_op_s == OP_WRITE) ? P_WDATA : P_PEND;
                end else begin
                    state_nxt_s = P_IDLE;
                end
            end
            P_WDATA: state_nxt_s = P_PEND;
            P_PEND: begin
                if (done) begin
                    state_nxt_s = P_IDLE;
                end else begin
                    state_nxt_s = P_PEND;
                end
            end
            default: state_nxt_s = P_IDLE;
        endcase
    end

    // State register plus op/address/data latches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= P_IDLE;
            op      <= OP_READ;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == P_IDLE && enable) begin
                op   <= dec_op_s;
                addr <= in_ad;
            end
            if (state_r == P_WDATA) begin
                wdata <= in_ad;
            end
        end
    end

endmodule

// File: rtl/csm_arbiter.sv
// Two-processor shared-memory arbiter: round-robin grant, hold/release bus
// lock, registered memory strobes and per-port completion status.
module csm_arbiter
    import csm_pkg::*;
#(
    parameter int DATABITS = 8,
    parameter int ERRBITS  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATABITS-1:0] A_in_AD,
    input  logic                A_rw,
    input  logic                A_enable,
    input  logic                A_hold,
    input  logic                A_release,
    output logic                A_ack,
    output logic [ERRBITS-1:0]  A_err,
    output logic [DATABITS-1:0] A_out_data,
    input  logic [DATABITS-1:0] B_in_AD,
    input  logic                B_rw,
    input  logic                B_enable,
    input  logic                B_hold,
    input  logic                B_release,
    output logic                B_ack,
    output logic [ERRBITS-1:0]  B_err,
    output logic [DATABITS-1:0] B_out_data,
    output logic [DATABITS-1:0] mem_addr,
    output logic [DATABITS-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATABITS-1:0] mem_rdata
);

    logic                a_pend_s, b_pend_s, a_done_s, b_done_s;
    op_t                 a_op_s, b_op_s;
    logic [DATABITS-1:0] a_addr_s, b_addr_s, a_wdata_s, b_wdata_s;

    csm_port_capture #(.DATABITS(DATABITS)) u_port_a (
        .clk     (clk),
        .reset_n (reset_n),
        .in_ad   (A_in_AD),
        .rw      (A_rw),
        .enable  (A_enable),
        .hold    (A_hold),
        .rel     (A_release),
        .done    (a_done_s),
        .ack     (A_ack),
        .pend    (a_pend_s),
        .op      (a_op_s),
        .addr    (a_addr_s),
        .wdata   (a_wdata_s)
    );

    csm_port_capture #(.DATABITS(DATABITS)) u_port_b (
        .clk     (clk),
        .reset_n (reset_n),
        .in_ad   (B_in_AD),
        .rw      (B_rw),
        .enable  (B_enable),
        .hold    (B_hold),
        .rel     (B_release),
        .done    (b_done_s),
        .ack     (B_ack),
        .pend    (b_pend_s),
        .op      (b_op_s),
        .addr    (b_addr_s),
        .wdata   (b_wdata_s)
    );

    arb_state_t          arb_r, arb_nxt_s;
    owner_t              lock_r, lock_nxt_s, self_s;
    logic                prio_b_r, gnt_b_r, contended_r;
    logic                mem_we_r, mem_re_r;
    logic [DATABITS-1:0] mem_addr_r, mem_wdata_r;
    logic [ERRBITS-1:0]  a_err_r, b_err_r;
    logic [DATABITS-1:0] a_out_r, b_out_r;

    logic                any_pend_s, both_pend_s, sel_b_s, cur_b_s, owner_ok_s;
    op_t                 cur_op_s;
    logic [DATABITS-1:0] cur_addr_s, cur_wdata_s;
    logic                issue_we_s, issue_re_s, complete_s, rd_done_s;
    logic [1:0]          err_nxt_s;

    assign any_pend_s  = a_pend_s | b_pend_s;
    assign both_pend_s = a_pend_s & b_pend_s;

    // While idle the candidate is chosen from pending ports; afterwards the grant is held.
    always_comb begin
        sel_b_s     = both_pend_s ? prio_b_r : b_pend_s;
        cur_b_s     = (arb_r == ARB_IDLE) ? sel_b_s : gnt_b_r;
        cur_op_s    = cur_b_s ? b_op_s    : a_op_s;
        cur_addr_s  = cur_b_s ? b_addr_s  : a_addr_s;
        cur_wdata_s = cur_b_s ? b_wdata_s : a_wdata_s;
        self_s      = cur_b_s ? OWN_B     : OWN_A;
        owner_ok_s  = (lock_r == OWN_NONE) || (lock_r == self_s);
    end

    // Arbiter next state; memory strobes are issued on the grant edge so they
    // are visible for exactly the execute cycle.
    always_comb begin
        arb_nxt_s  = arb_r;
        lock_nxt_s = lock_r;
        issue_we_s = 1'b0;
        issue_re_s = 1'b0;
        complete_s = 1'b0;
        rd_done_s  = 1'b0;
        err_nxt_s  = ERR_NONE;
        case (arb_r)
            ARB_IDLE: begin
                if (any_pend_s) begin
                    arb_nxt_s  = ARB_EXEC;
                    issue_re_s = (cur_op_s == OP_READ)  && owner_ok_s;
                    issue_we_s = (cur_op_s == OP_WRITE) && owner_ok_s;
                end else begin
                    arb_nxt_s = ARB_IDLE;
                end
            end
            ARB_EXEC: begin
                complete_s = 1'b1;
                arb_nxt_s  = ARB_IDLE;
                case (cur_op_s)
                    OP_READ: begin
                        if (owner_ok_s) begin
                            complete_s = 1'b0;
                            arb_nxt_s  = ARB_RD;
                        end else begin
                            err_nxt_s = ERR_LOCKED;
                        end
                    end
                    OP_WRITE: begin
                        err_nxt_s = owner_ok_s ? ERR_NONE : ERR_LOCKED;
                    end
                    OP_HOLD: begin
                        if (owner_ok_s) begin
                            lock_nxt_s = self_s;
                        end else begin
                            err_nxt_s = ERR_LOCKED;
                        end
                    end
                    OP_RELEASE: begin
                        if (lock_r == self_s) begin
                            lock_nxt_s = OWN_NONE;
                        end else begin
                            err_nxt_s = ERR_NOT_OWNER;
                        end
                    end
                    default: err_nxt_s = ERR_PROTO;
                endcase
            end
            ARB_RD: begin
                complete_s = 1'b1;
                rd_done_s  = 1'b1;
                arb_nxt_s  = ARB_IDLE;
            end
            default: arb_nxt_s = ARB_IDLE;
        endcase
        a_done_s = complete_s & ~cur_b_s;
        b_done_s = complete_s &  cur_b_s;
    end

    // Arbiter state, lock, memory interface and per-port status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            arb_r       <= ARB_IDLE;
            lock_r      <= OWN_NONE;
            prio_b_r    <= 1'b0;
            gnt_b_r     <= 1'b0;
            contended_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            a_err_r     <= ERRBITS'(ERR_NONE);
            b_err_r     <= ERRBITS'(ERR_NONE);
            a_out_r     <= '0;
            b_out_r     <= '0;
        end else begin
            arb_r    <= arb_nxt_s;
            lock_r   <= lock_nxt_s;
            mem_we_r <= issue_we_s;
            mem_re_r <= issue_re_s;
            if (arb_r == ARB_IDLE && any_pend_s) begin
                gnt_b_r     <= sel_b_s;
                contended_r <= both_pend_s;
            end
            if (issue_we_s || issue_re_s) begin
                mem_addr_r <= cur_addr_s;
            end
            if (issue_we_s) begin
                mem_wdata_r <= cur_wdata_s;
            end
            if (a_done_s) begin
                a_err_r <= ERRBITS'(err_nxt_s);
            end
            if (b_done_s) begin
                b_err_r <= ERRBITS'(err_nxt_s);
            end
            if (rd_done_s && !cur_b_s) begin
                a_out_r <= mem_rdata;
            end
            if (rd_done_s && cur_b_s) begin
                b_out_r <= mem_rdata;
            end
            // Only a contested grant moves priority, so an uncontested follow-up keeps it.
            if (complete_s && contended_r) begin
                prio_b_r <= ~gnt_b_r;
            end
        end
    end

    assign A_err      = a_err_r;
    assign B_err      = b_err_r;
    assign A_out_data = a_out_r;
    assign B_out_data = b_out_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;
    assign mem_re     = mem_re_r;

endmodule

// File: tb/tb_csm_arbiter.sv
// Self-checking bench for csm_arbiter: table of single-port requests, hand
// sequences for contention and reset, and a memory-access scoreboard.
module tb_csm_arbiter;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0][7:0] ad = '0;
    logic [1:0]      rw = '0, en = '0, hd = '0, rl = '0;
    wire  [1:0]      ack_v;
    wire  [1:0][1:0] err_v;
    wire  [1:0][7:0] out_v;
    wire  [7:0]      mem_addr, mem_wdata;
    wire             mem_we, mem_re;
    logic [7:0]      mem_rdata = 8'h00;
    logic [7:0]      mem [256];

    int total = 0;
    int bad   = 0;
    logic mon_on = 1'b0;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } mx_t;
    mx_t sbq[$];

    typedef struct {
        int         p;
        logic       rw, hd, rl;
        logic [7:0] addr, wd;
        logic [1:0] err;
        logic [7:0] outv;
        int         lat;
        logic       mem;
    } vec_t;
    vec_t tbl[16];

    csm_arbiter #(.DATABITS(8), .ERRBITS(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .A_in_AD    (ad[0]),
        .A_rw       (rw[0]),
        .A_enable   (en[0]),
        .A_hold     (hd[0]),
        .A_release  (rl[0]),
        .A_ack      (ack_v[0]),
        .A_err      (err_v[0]),
        .A_out_data (out_v[0]),
        .B_in_AD    (ad[1]),
        .B_rw       (rw[1]),
        .B_enable   (en[1]),
        .B_hold     (hd[1]),
        .B_release  (rl[1]),
        .B_ack      (ack_v[1]),
        .B_err      (err_v[1]),
        .B_out_data (out_v[1]),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous memory macro: read data one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every memory strobe must match the next expected access.
    always @(negedge clk) begin
        if (mon_on && (mem_we || mem_re)) begin
            mx_t e;
            chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_unexpected: got we=%0d addr=%0h want no access", mem_we, mem_addr);
            end else begin
                e = sbq.pop_front();
                chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                if (e.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
            end
        end
    end

    task automatic do_req(input int p, input logic rw_i, input logic hd_i, input logic rl_i,
                          input logic [7:0] addr, input logic [7:0] wd, input logic [1:0] xerr,
                          input logic [7:0] xout, input int xlat, input logic xmem);
        int lat;
        if (xmem) sbq.push_back({rw_i, addr, wd});
        @(negedge clk);
        en[p] = 1'b1; rw[p] = rw_i; hd[p] = hd_i; rl[p] = rl_i; ad[p] = addr;
        @(posedge clk);
        #1;
        en[p] = 1'b0; hd[p] = 1'b0; rl[p] = 1'b0; ad[p] = wd;
        lat = 0;
        while (!ack_v[p] && lat < 12) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk($sformatf("latency_p%0d", p), lat, xlat);
        chk($sformatf("err_p%0d", p), {30'd0, err_v[p]}, {30'd0, xerr});
        chk($sformatf("out_p%0d", p), {24'd0, out_v[p]}, {24'd0, xout});
    endtask

    task automatic do_pair(input logic rw_i, input logic hd_i, input logic [7:0] aa, input logic [7:0] ab,
                           input logic [1:0] ea, input logic [1:0] eb, input logic [7:0] oa,
                           input logic [7:0] ob, input int xla, input int xlb);
        int la, lb;
        @(negedge clk);
        en = 2'b11; rw = {rw_i, rw_i}; hd = {hd_i, hd_i}; ad[0] = aa; ad[1] = ab;
        @(posedge clk);
        #1;
        en = 2'b00; hd = 2'b00;
        la = -1; lb = -1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (la < 0 && ack_v[0]) la = k;
            if (lb < 0 && ack_v[1]) lb = k;
            if (la >= 0 && lb >= 0) break;
        end
        chk("pair_lat_a", la, xla);
        chk("pair_lat_b", lb, xlb);
        chk("pair_err_a", {30'd0, err_v[0]}, {30'd0, ea});
        chk("pair_err_b", {30'd0, err_v[1]}, {30'd0, eb});
        chk("pair_out_a", {24'd0, out_v[0]}, {24'd0, oa});
        chk("pair_out_b", {24'd0, out_v[1]}, {24'd0, ob});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        //          p  rw    hd    rl    addr   wd     err    out    lat mem
        tbl[0]  = '{0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h5A, 2'b00, 8'h00, 3, 1'b1};
        tbl[1]  = '{0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 2'b00, 8'h5A, 3, 1'b1};
        tbl[2]  = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 8'h5A, 2, 1'b0};
        tbl[3]  = '{1, 1'b1, 1'b0, 1'b0, 8'h20, 8'hFF, 2'b01, 8'h00, 3, 1'b0};
        tbl[4]  = '{0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h11, 2'b00, 8'h5A, 3, 1'b1};
        tbl[5]  = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 8'h5A, 2, 1'b0};
        tbl[6]  = '{1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b10, 8'h00, 2, 1'b0};
        tbl[7]  = '{1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 2'b01, 8'h00, 2, 1'b0};
        tbl[8]  = '{0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 8'h5A, 2, 1'b0};
        tbl[9]  = '{1, 1'b1, 1'b0, 1'b0, 8'h20, 8'hFF, 2'b01, 8'h00, 3, 1'b0};
        tbl[10] = '{0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 8'h5A, 2, 1'b0};
        tbl[11] = '{0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b10, 8'h5A, 2, 1'b0};
        tbl[12] = '{1, 1'b1, 1'b0, 1'b0, 8'h20, 8'hFF, 2'b00, 8'h00, 3, 1'b1};
        tbl[13] = '{1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 2'b00, 8'hFF, 3, 1'b1};
        tbl[14] = '{0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 2'b00, 8'h5A, 3, 1'b1};
        tbl[15] = '{1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 8'hFF, 2, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        chk("rst_ack", {30'd0, ack_v}, 32'd3);
        chk("rst_err", {28'd0, err_v}, 32'd0);
        chk("rst_out", {16'd0, out_v}, 32'd0);
        chk("rst_mem", {14'd0, mem_we, mem_re, mem_addr, mem_wdata}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            do_req(tbl[i].p, tbl[i].rw, tbl[i].hd, tbl[i].rl, tbl[i].addr, tbl[i].wd,
                   tbl[i].err, tbl[i].outv, tbl[i].lat, tbl[i].mem);
        end
        chk("mem_0x20", {24'd0, mem[8'h20]}, 32'hFF);

        do_req(0, 1'b1, 1'b0, 1'b0, 8'h01, 8'hA1, 2'b00, 8'h5A, 3, 1'b1);
        do_req(1, 1'b1, 1'b0, 1'b0, 8'h02, 8'hB2, 2'b00, 8'hFF, 3, 1'b1);

        // Simultaneous reads: A wins first, then B wins the next contest.
        sbq.push_back({1'b0, 8'h01, 8'h00});
        sbq.push_back({1'b0, 8'h02, 8'h00});
        do_pair(1'b0, 1'b0, 8'h01, 8'h02, 2'b00, 2'b00, 8'hA1, 8'hB2, 3, 6);
        sbq.push_back({1'b0, 8'h01, 8'h00});
        sbq.push_back({1'b0, 8'h10, 8'h00});
        do_pair(1'b0, 1'b0, 8'h10, 8'h01, 2'b00, 2'b00, 8'h5A, 8'hA1, 6, 3);

        // Simultaneous holds: priority is back on A, B is refused.
        do_pair(1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5A, 8'hA1, 2, 4);
        do_req(1, 1'b1, 1'b0, 1'b0, 8'h21, 8'h33, 2'b01, 8'hA1, 3, 1'b0);
        do_req(0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 8'h5A, 2, 1'b0);

        // Reset between the address and data cycles of a write while A owns the lock.
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'h40;
        @(posedge clk);
        #1;
        en[0] = 1'b0; ad[0] = 8'h99; reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_mid_ack", {31'd0, ack_v[0]}, 32'd1);
        chk("rst_mid_err", {30'd0, err_v[0]}, 32'd0);
        chk("rst_mid_out", {24'd0, out_v[0]}, 32'd0);
        repeat (5) @(posedge clk);
        chk("rst_mid_nowrite", {24'd0, mem[8'h40]}, 32'd0);
        do_req(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h77, 2'b00, 8'h00, 3, 1'b1);

        repeat (3) @(posedge clk);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
